// File: rtl/delay_sum_beamformer_pkg.sv
// -----------------------------------------------------------------------------
// beamformer_pkg
// Shared definitions for the delay-and-sum beamformer slice:
//   - default configuration and derived widths (lane count, adder width)
//   - slot-position helpers for the I2S frame (capture offset, push index)
//   - slot phase enum used to decode the capture windows
//   - saturate helper used by the BF_SATURATE_EN build of the top
// -----------------------------------------------------------------------------
package beamformer_pkg;

  localparam int DEF_CHANNELS    = 4;
  localparam int DEF_SAMPLE_BITS = 12;
  localparam int DEF_SLOT_BITS   = 16;
  localparam int DEF_DEPTH       = 8;

  // I2S: the MSB of each slot arrives one clock after the WS transition.
  localparam int CAP_OFFSET = 1;

  function automatic int lanes_of(input int channels);
    return 2 * channels;
  endfunction

  // Full-precision width of the lane sum; cannot overflow for any input mix.
  function automatic int sum_width(input int sample_bits, input int lanes);
    return sample_bits + $clog2(lanes);
  endfunction

  // Last clock of the frame; the captured words move into the delay lines here.
  function automatic int push_index(input int slot_bits);
    return 2 * slot_bits - 1;
  endfunction

  localparam int DEF_LANES = lanes_of(DEF_CHANNELS);
  localparam int DEF_SUM_W = sum_width(DEF_SAMPLE_BITS, DEF_LANES);

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_LEFT  = 2'd1,
    SLOT_RIGHT = 2'd2
  } slot_e;

  // Clip a signed value to the signed range of a 'bits'-wide word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int               bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/delay_sum_beamformer_if.sv
// -----------------------------------------------------------------------------
// delay_sum_beamformer_if
// Configuration bus and beamformed output bundle of the beamformer.
//   cfg_valid / cfg_lane / cfg_delay : delay-register write port
//   ws_out / sd_out                  : I2S output (word select, serial data)
//   sum_out / sum_valid              : parallel beamformed sample + frame pulse
//   sat_flag                         : clipping indicator (BF_SATURATE_EN only)
// Modports: slave = beamformer side, master = controller / consumer side.
// -----------------------------------------------------------------------------
interface delay_sum_beamformer_if
  import beamformer_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS
);
  localparam int LW = $clog2(lanes_of(CHANNELS));
  localparam int DW = $clog2(DEPTH);

  logic                   cfg_valid;
  logic [LW-1:0]          cfg_lane;
  logic [DW-1:0]          cfg_delay;
  logic                   ws_out;
  logic                   sd_out;
  logic [SAMPLE_BITS-1:0] sum_out;
  logic                   sum_valid;
`ifdef BF_SATURATE_EN
  logic                   sat_flag;
`endif

  modport slave (
    input  cfg_valid, cfg_lane, cfg_delay,
`ifdef BF_SATURATE_EN
    output sat_flag,
`endif
    output ws_out, sd_out, sum_out, sum_valid
  );

  modport master (
    output cfg_valid, cfg_lane, cfg_delay,
`ifdef BF_SATURATE_EN
    input  sat_flag,
`endif
    input  ws_out, sd_out, sum_out, sum_valid
  );

endinterface

// File: rtl/delay_sum_beamformer_lane_delay.sv
// -----------------------------------------------------------------------------
// bf_lane_delay
// One lane's delay line: DEPTH x SAMPLE_BITS shift line (entry 0 = newest),
// its programmable delay register, and the tap mux selecting entry[delay].
//   clk, reset  : clock, synchronous active-high reset
//   push        : shift push_data into entry 0 (once per frame)
//   push_data   : captured sample for this lane
//   cfg_we      : write cfg_delay into the delay register
//   cfg_delay   : requested delay in frames (values >= DEPTH clamp to DEPTH-1)
//   tap         : delayed sample
// -----------------------------------------------------------------------------
module bf_lane_delay
  import beamformer_pkg::*;
#(
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int DEPTH       = DEF_DEPTH,
  localparam int DW         = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [SAMPLE_BITS-1:0] push_data,
  input  logic                   cfg_we,
  input  logic [DW-1:0]          cfg_delay,
  output logic [SAMPLE_BITS-1:0] tap
);

  logic [SAMPLE_BITS-1:0] line_q [DEPTH];
  logic [DW-1:0]          delay_q;

  // NOTE: the delay line is reset entry by entry because a reset must flush
  // stale audio; that forces flops rather than a RAM, which is fine at this depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
      delay_q <= '0;
    end else begin
      if (push) begin
        line_q[0] <= push_data;
        for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
      end
      // Only reachable for non-power-of-2 DEPTH, where the field can exceed it.
      if (cfg_we) delay_q <= (int'(cfg_delay) >= DEPTH) ? DW'(DEPTH - 1) : cfg_delay;
    end
  end

  assign tap = line_q[delay_q];

endmodule

// File: rtl/delay_sum_beamformer.sv
// -----------------------------------------------------------------------------
// delay_sum_beamformer
// Multi-channel delay-and-sum beamformer on a single I2S bit clock.
//   clk     : system clock and I2S SCK (rising edge)
//   reset   : synchronous active-high reset
//   sd_in   : one serial I2S input per stereo channel
//   bf      : delay_sum_beamformer_if.slave (config bus, ws_out, sd_out,
//             sum_out, sum_valid, and sat_flag when saturating)
// Frame timeline (bit_cnt value at the active edge):
//   CAP_OFFSET..          left/right capture windows, MSB first
//   2*SLOT_BITS-1         captured words pushed into every lane's delay line
//   0                     taps summed, sum_out/sum_valid updated, serialiser loaded
// Build option: define BF_SATURATE_EN to saturate the sum into SAMPLE_BITS and
// add sat_flag; otherwise sum_out is the sum scaled down by 2^$clog2(lanes).
// -----------------------------------------------------------------------------
module delay_sum_beamformer
  import beamformer_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int SLOT_BITS   = DEF_SLOT_BITS,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         sd_in,
  delay_sum_beamformer_if.slave       bf
);

  localparam int LANES = lanes_of(CHANNELS);
  localparam int LW    = $clog2(LANES);
  localparam int SUM_W = sum_width(SAMPLE_BITS, LANES);
  localparam int SHIFT = $clog2(LANES);
  localparam int CW    = $clog2(2 * SLOT_BITS);

  localparam logic [CW-1:0] FRAME_START = '0;
  localparam logic [CW-1:0] SLOT_START  = CW'(SLOT_BITS);
  localparam logic [CW-1:0] L_FIRST     = CW'(CAP_OFFSET);
  localparam logic [CW-1:0] L_LAST      = CW'(CAP_OFFSET + SAMPLE_BITS - 1);
  localparam logic [CW-1:0] R_FIRST     = CW'(SLOT_BITS + CAP_OFFSET);
  localparam logic [CW-1:0] R_LAST      = CW'(SLOT_BITS + CAP_OFFSET + SAMPLE_BITS - 1);
  localparam logic [CW-1:0] PUSH_IDX    = CW'(push_index(SLOT_BITS));

  logic [CW-1:0]                 bit_cnt;
  logic [CW-1:0]                 next_cnt;
  logic                          push;
  logic                          frame_seen;
  slot_e                         phase;
  logic [SAMPLE_BITS-1:0]        cap_l [CHANNELS];
  logic [SAMPLE_BITS-1:0]        cap_r [CHANNELS];
  logic [LANES-1:0]              lane_we;
  logic signed [SAMPLE_BITS-1:0] taps [LANES];
  logic signed [SUM_W-1:0]       sum_full;
  logic [SAMPLE_BITS-1:0]        conv;
  logic [SAMPLE_BITS-1:0]        ser_q;

  assign next_cnt = (bit_cnt == PUSH_IDX) ? '0 : bit_cnt + 1'b1;
  assign push     = (bit_cnt == PUSH_IDX);

  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    phase = SLOT_IDLE;
    if (bit_cnt >= L_FIRST && bit_cnt <= L_LAST)      phase = SLOT_LEFT;
    else if (bit_cnt >= R_FIRST && bit_cnt <= R_LAST) phase = SLOT_RIGHT;
  end

  // Lane 2c = left of channel c, lane 2c+1 = right. Out-of-range lane numbers
  // match no instance, so such writes are dropped.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [SAMPLE_BITS-1:0] word;
    if (l % 2 == 0) begin : g_left
      assign word = cap_l[l/2];
    end else begin : g_right
      assign word = cap_r[l/2];
    end

    assign lane_we[l] = bf.cfg_valid && (bf.cfg_lane == LW'(l));

    bf_lane_delay #(
      .SAMPLE_BITS (SAMPLE_BITS),
      .DEPTH       (DEPTH)
    ) u_delay (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (word),
      .cfg_we    (lane_we[l]),
      .cfg_delay (bf.cfg_delay),
      .tap       (taps[l])
    );
  end

  // NOTE: the accumulator is a blocking running total inside always_comb; each
  // iteration must see the previous partial sum, so <= would be wrong here.
  always_comb begin
    sum_full = '0;
    for (int i = 0; i < LANES; i++) sum_full = sum_full + SUM_W'(taps[i]);
  end

`ifdef BF_SATURATE_EN
  logic signed [63:0] wide_sum;
  logic signed [63:0] wide_sat;
  logic               clip;
  assign wide_sum = 64'(sum_full);
  assign wide_sat = saturate(wide_sum, SAMPLE_BITS);
  assign conv     = wide_sat[SAMPLE_BITS-1:0];
  assign clip     = (wide_sat != wide_sum);
`else
  // Keep the top SAMPLE_BITS of the sum: an arithmetic divide by 2^SHIFT.
  assign conv = SAMPLE_BITS'(sum_full >>> SHIFT);
`endif

  // NOTE: all state here is updated with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt      <= '0;
      frame_seen   <= 1'b0;
      ser_q        <= '0;
      bf.ws_out    <= 1'b0;
      bf.sd_out    <= 1'b0;
      bf.sum_out   <= '0;
      bf.sum_valid <= 1'b0;
`ifdef BF_SATURATE_EN
      bf.sat_flag  <= 1'b0;
`endif
      for (int c = 0; c < CHANNELS; c++) begin
        cap_l[c] <= '0;
        cap_r[c] <= '0;
      end
    end else begin
      bit_cnt   <= next_cnt;
      bf.ws_out <= (next_cnt >= SLOT_START);

      for (int c = 0; c < CHANNELS; c++) begin
        case (phase)
          SLOT_LEFT:  cap_l[c] <= {cap_l[c][SAMPLE_BITS-2:0], sd_in[c]};
          SLOT_RIGHT: cap_r[c] <= {cap_r[c][SAMPLE_BITS-2:0], sd_in[c]};
          default:    ;
        endcase
      end

      // The first sum after reset must wait for one complete captured frame.
      if (push) frame_seen <= 1'b1;

      bf.sum_valid <= 1'b0;
      if (bit_cnt == FRAME_START && frame_seen) begin
        bf.sum_out   <= conv;
        bf.sum_valid <= 1'b1;
`ifdef BF_SATURATE_EN
        bf.sat_flag  <= clip;
`endif
      end

      // sd_out is registered one clock ahead, so each slot's MSB is emitted from
      // the edge before its window opens: conv for the left slot (sum_out is
      // being written on that same edge), the held sum_out for the right slot.
      if (bit_cnt == L_FIRST - 1'b1) begin
        bf.sd_out <= conv[SAMPLE_BITS-1];
        ser_q     <= {conv[SAMPLE_BITS-2:0], 1'b0};
      end else if (bit_cnt == R_FIRST - 1'b1) begin
        bf.sd_out <= bf.sum_out[SAMPLE_BITS-1];
        ser_q     <= {bf.sum_out[SAMPLE_BITS-2:0], 1'b0};
      end else if ((bit_cnt >= L_FIRST && bit_cnt < L_LAST) ||
                   (bit_cnt >= R_FIRST && bit_cnt < R_LAST)) begin
        bf.sd_out <= ser_q[SAMPLE_BITS-1];
        ser_q     <= {ser_q[SAMPLE_BITS-2:0], 1'b0};
      end else begin
        bf.sd_out <= 1'b0;
      end
    end
  end

endmodule
